skullfet_bist: RTL and testbench

Parametrised built-in self-test engine for the SkullFET gate cells. It instantiates `CHANNELS` copies of a gate pair (one `skullfet_inverter`, one `skullfet_nand`) and drives each pair through all four input vectors. Each vector is held for a programmable settle time, then every gate output is compared against its truth table. Mismatches are accumulated into a saturating error count and a per-channel sticky fail mask. The block sits inside the tile top, between the dedicated input pins (control) and the output pins (status), replacing direct pin-to-gate wiring.

---
 rtl/skullfet_pkg.sv | 22 ++
 rtl/skullfet_bist_channel.sv | 38 +++
 rtl/skullfet_bist.sv | 155 +++++++++++++++
 tb/tb_skullfet_bist.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/skullfet_pkg.sv
// Shared types and helpers for the SkullFET gate-cell self-test engine.
package skullfet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    // Gate-select encodings for the mode input (00 behaves like MODE_BOTH).
    localparam logic [1:0] MODE_INV  = 2'b01;
    localparam logic [1:0] MODE_NAND = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Golden gate outputs for one stimulus pair, packed as {nand_y, inv_y}.
    function automatic logic [1:0] gate_expect(input logic a, input logic b);
        return {~(a & b), ~a};
    endfunction

endpackage

// File: rtl/skullfet_bist_channel.sv
// One gate pair under test: stimulus registers, an inverter, a NAND, and the
// per-gate compare against the truth table.
module skullfet_bist_channel (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,    // capture vec_i as the new stimulus
    input  logic [1:0] vec_i,     // {a, b}
    input  logic       inject_i,  // inverts both observed outputs
    input  logic [1:0] en_i,      // {nand enable, inv enable}
    output logic [1:0] y_o,       // raw {nand_y, inv_y}
    output logic [1:0] mis_o      // {nand mismatch, inv mismatch}
);
    import skullfet_pkg::*;

    logic       a_q, b_q;
    logic       inv_y, nand_y;
    logic [1:0] obs;

    // Stimulus registers, loaded once per vector in APPLY.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= 1'b0;
            b_q <= 1'b0;
        end else if (load_i) begin
            a_q <= vec_i[1];
            b_q <= vec_i[0];
        end
    end

    assign inv_y  = ~a_q;
    assign nand_y = ~(a_q & b_q);
    assign y_o    = {nand_y, inv_y};

    // Fault injection only affects what the checker sees, never the pins.
    assign obs   = y_o ^ {2{inject_i}};
    assign mis_o = (obs ^ gate_expect(a_q, b_q)) & en_i;

endmodule

// File: rtl/skullfet_bist.sv
// Self-test sequencer: walks every channel through all four input vectors,
// checks the gate outputs and accumulates a saturating error count and a
// sticky per-channel fail mask.
module skullfet_bist #(
    parameter int CHANNELS      = 4,
    parameter int SETTLE_CYCLES = 3,
    parameter int ERR_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [CHANNELS-1:0]   inject,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [CHANNELS-1:0]   fail_mask,
    output logic [2*CHANNELS-1:0] gate_y
);
    import skullfet_pkg::*;

    // Wide enough for 2*CHANNELS (max 16) mismatches per vector.
    localparam int HIT_W = 5;
    localparam int SUM_W = ERR_W + HIT_W;
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    state_t                state_q, state_d;
    logic [1:0]            v_q, v_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [1:0]            mode_q, mode_d;
    logic [ERR_W-1:0]      err_q, err_d;
    logic [CHANNELS-1:0]   mask_q, mask_d;

    logic [1:0]            en;
    logic [2*CHANNELS-1:0] mis;
    logic [CHANNELS-1:0]   chan_fail;
    logic [HIT_W-1:0]      hits;

    // Adds this vector's hits to the running count, clamping at all-ones.
    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc,
                                                 input logic [HIT_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(acc) + SUM_W'(inc);
        return (sum > SUM_W'(ERR_MAX)) ? ERR_MAX : sum[ERR_W-1:0];
    endfunction

    // Decode the latched mode into {nand, inv} check enables.
    always_comb begin
        case (mode_q)
            MODE_INV:  en = 2'b01;
            MODE_NAND: en = 2'b10;
            MODE_BOTH: en = 2'b11;
            default:   en = 2'b11;
        endcase
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [1:0] vec;
        // Rotate the vector per channel so neighbours never see the same inputs.
        assign vec = v_q + 2'(i % 4);

        skullfet_bist_channel u_ch (
            .clk      (clk),
            .rst      (rst),
            .load_i   (state_q == ST_APPLY),
            .vec_i    (vec),
            .inject_i (inject[i]),
            .en_i     (en),
            .y_o      (gate_y[2*i +: 2]),
            .mis_o    (mis[2*i +: 2])
        );

        assign chan_fail[i] = |mis[2*i +: 2];
    end

    // Count mismatching gate samples across all channels.
    always_comb begin
        hits = '0;
        for (int i = 0; i < 2*CHANNELS; i++) begin
            hits = hits + HIT_W'(mis[i]);
        end
    end

    // Next-state logic for the sequencer, counters and result registers.
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        err_d   = err_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_APPLY;
                    v_d     = 2'd0;
                    cnt_d   = 8'd0;
                    mode_d  = mode;
                    err_d   = '0;
                    mask_d  = '0;
                end
            end
            ST_APPLY: begin
                state_d = ST_SETTLE;
                cnt_d   = 8'd0;
            end
            ST_SETTLE: begin
                if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SAMPLE: begin
                err_d  = sat_add(err_q, hits);
                mask_d = mask_q | chan_fail;
                if (v_q == 2'd3) begin
                    state_d = ST_DONE;
                end else begin
                    v_d     = v_q + 2'd1;
                    state_d = ST_APPLY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers; reset discards any partial run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            v_q     <= 2'd0;
            cnt_q   <= 8'd0;
            mode_q  <= MODE_BOTH;
            err_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
        end
    end

    assign busy      = (state_q == ST_APPLY) || (state_q == ST_SETTLE) ||
                       (state_q == ST_SAMPLE);
    assign done      = (state_q == ST_DONE);
    assign pass      = done && (mask_q == '0);
    assign err_count = err_q;
    assign fail_mask = mask_q;

endmodule

// File: tb/tb_skullfet_bist.sv
// Bench for skullfet_bist: table-driven fixed-fault runs, randomized runs
// against a reference model, and hand-written reset/restart sequences.
module tb_skullfet_bist;
    localparam int CH = 4;
    localparam int S  = 3;
    localparam int RUN_CYC = 4 * (S + 2);

    logic          clk, rst, start;
    logic [1:0]    mode;
    logic [CH-1:0] inject;

    logic          busy, done, pass;
    logic [7:0]    err;
    logic [CH-1:0] mask;
    logic [2*CH-1:0] gy;

    logic          busy3, done3, pass3;
    logic [2:0]    err3;
    logic [CH-1:0] mask3;
    logic [2*CH-1:0] gy3;

    int total = 0;
    int bad   = 0;

    skullfet_bist #(.CHANNELS(CH), .SETTLE_CYCLES(S), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .inject(inject),
        .busy(busy), .done(done), .pass(pass), .err_count(err),
        .fail_mask(mask), .gate_y(gy)
    );

    skullfet_bist #(.CHANNELS(CH), .SETTLE_CYCLES(S), .ERR_W(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .inject(inject),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_mask(mask3), .gate_y(gy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    md;
        logic [CH-1:0] inj;
        int            exp_err;
        logic [CH-1:0] exp_mask;
        logic          exp_pass;
        int            exp_err3;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One complete run. The model counts mismatches at each SAMPLE cycle:
    // a correct gate disagrees with its truth table exactly when injected.
    task automatic do_run(input logic [1:0] md, input logic rnd,
                          input logic [CH-1:0] fix_inj, input logic mid_start,
                          output int m_err, output logic [CH-1:0] m_mask);
        int tbad;
        logic [2*CH-1:0] gy_exp;
        int vec, a, b;
        tbad   = 0;
        m_err  = 0;
        m_mask = '0;
        @(negedge clk);
        start  = 1'b1;
        mode   = md;
        inject = fix_inj;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= RUN_CYC; k++) begin
            if (rnd) begin
                inject = CH'($urandom);
                mode   = 2'($urandom);
            end
            if (mid_start && k == 7) begin
                start = 1'b1;
                mode  = ~md;
            end
            @(negedge clk);
            if (!(busy && !done && busy3 && !done3)) tbad++;
            if (k % (S + 2) == 0) begin
                for (int i = 0; i < CH; i++) begin
                    if (inject[i]) begin
                        if (md != 2'b10) m_err++;
                        if (md != 2'b01) m_err++;
                        m_mask[i] = 1'b1;
                    end
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        if (!(done && !busy && done3 && !busy3)) tbad++;
        chk("run_timing", tbad, 0);
        // Last vector applied was v=3, so channel i holds (3+i) mod 4.
        for (int i = 0; i < CH; i++) begin
            vec = (3 + i) % 4;
            a = vec / 2;
            b = vec % 2;
            gy_exp[2*i]   = (a == 0);
            gy_exp[2*i+1] = !(a == 1 && b == 1);
        end
        chk("gate_y_final", int'(gy), int'(gy_exp));
    endtask

    vec_t tbl[6];
    int me;
    logic [CH-1:0] mm;

    initial begin
        tbl[0] = '{2'b11, 4'b0000, 0,  4'b0000, 1'b1, 0};
        tbl[1] = '{2'b11, 4'b0001, 8,  4'b0001, 1'b0, 7};
        tbl[2] = '{2'b01, 4'b0001, 4,  4'b0001, 1'b0, 4};
        tbl[3] = '{2'b10, 4'b0100, 4,  4'b0100, 1'b0, 4};
        tbl[4] = '{2'b00, 4'b0011, 16, 4'b0011, 1'b0, 7};
        tbl[5] = '{2'b11, 4'b1111, 32, 4'b1111, 1'b0, 7};

        rst = 1'b1; start = 1'b0; mode = 2'b00; inject = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_mask", int'(mask), 0);
        chk("rst_gate_y", int'(gy), 8'hFF);

        // Reset wins over a simultaneous start.
        rst = 1'b1; start = 1'b1; mode = 2'b11;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", int'(busy), 0);

        for (int t = 0; t < 6; t++) begin
            do_run(tbl[t].md, 1'b0, tbl[t].inj, 1'b0, me, mm);
            chk($sformatf("tbl%0d_err", t), int'(err), tbl[t].exp_err);
            chk($sformatf("tbl%0d_mask", t), int'(mask), int'(tbl[t].exp_mask));
            chk($sformatf("tbl%0d_pass", t), int'(pass), int'(tbl[t].exp_pass));
            chk($sformatf("tbl%0d_err3", t), int'(err3), tbl[t].exp_err3);
            chk($sformatf("tbl%0d_mask3", t), int'(mask3), int'(tbl[t].exp_mask));
        end

        // Restart from DONE with a stray start pulse mid-run.
        chk("done_before_restart", int'(done), 1);
        do_run(2'b11, 1'b0, 4'b0000, 1'b1, me, mm);
        chk("midstart_pass", int'(pass), 1);
        chk("midstart_err", int'(err), 0);

        // Randomized runs: inject changes every cycle, mode wiggles after start.
        for (int r = 0; r < 8; r++) begin
            do_run(2'($urandom), 1'b1, CH'($urandom), 1'b0, me, mm);
            chk($sformatf("rnd%0d_err", r), int'(err), (me > 255) ? 255 : me);
            chk($sformatf("rnd%0d_err3", r), int'(err3), (me > 7) ? 7 : me);
            chk($sformatf("rnd%0d_mask", r), int'(mask), int'(mm));
            chk($sformatf("rnd%0d_pass", r), int'(pass), int'(mm == '0));
        end

        // Reset during cycle 10 of a faulted run.
        @(negedge clk);
        start = 1'b1; mode = 2'b11; inject = 4'b1111;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_pass", int'(pass), 0);
        chk("midrst_err", int'(err), 0);
        chk("midrst_mask", int'(mask), 0);
        chk("midrst_gate_y", int'(gy), 8'hFF);
        do_run(2'b11, 1'b0, 4'b0000, 1'b0, me, mm);
        chk("post_rst_pass", int'(pass), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
